// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU; logic/add/sub finish in one cycle, shifts step one bit per cycle.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 1000).
module alu_seq #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         Carry,
  output logic         Negative,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_ASR = 4'b0111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [1:0] S_MULT  = 2'd2;
`endif

  logic [1:0]    state;
  logic [3:0]    op_q;
  logic [W-1:0]  work;
  logic [CW-1:0] cnt;

  logic [SHW-1:0] amt;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W-1:0]   one_res;
  logic           one_carry;
  logic           start_shift;

  // Results for everything that completes in the accept cycle; a zero-amount shift passes A through.
  always_comb begin
    amt       = InputB[SHW-1:0];
    sum       = {1'b0, InputA} + {1'b0, InputB};
    diff      = {1'b0, InputA} - {1'b0, InputB};
    one_res   = '0;
    one_carry = 1'b0;
    case (OP)
      OP_ADD: begin
        one_res   = sum[W-1:0];
        one_carry = sum[W];
      end
      OP_SUB: begin
        one_res   = diff[W-1:0];
        one_carry = diff[W];
      end
      OP_XOR:                 one_res = InputA ^ InputB;
      OP_AND:                 one_res = InputA & InputB;
      OP_OR:                  one_res = InputA | InputB;
      OP_SHL, OP_SHR, OP_ASR: one_res = InputA;
      default:                one_res = '0;
    endcase
    start_shift = ((OP == OP_SHL) || (OP == OP_SHR) || (OP == OP_ASR)) && (amt != '0);
  end

  logic [W-1:0] shifted;
  logic         shift_bit;

  always_comb begin
    shifted   = work;
    shift_bit = 1'b0;
    case (op_q)
      OP_SHL: begin
        shifted   = {work[W-2:0], 1'b0};
        shift_bit = work[W-1];
      end
      OP_SHR: begin
        shifted   = {1'b0, work[W-1:1]};
        shift_bit = work[0];
      end
      OP_ASR: begin
        shifted   = {work[W-1], work[W-1:1]};
        shift_bit = work[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Product accumulates in {hi, lo}; lo starts as B and its LSB selects whether A is added.
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] next_hi;
  logic [W-1:0] next_lo;
  logic [W:0]   mul_sum;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, work} : '0);
    next_hi = mul_sum[W:1];
    next_lo = {mul_sum[0], lo[W-1:1]};
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      work     <= '0;
      cnt      <= '0;
      Out      <= '0;
      Zero     <= 1'b1;
      Carry    <= 1'b0;
      Negative <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi       <= '0;
      lo       <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q <= OP;
            work <= InputA;
            if (start_shift) begin
              state <= S_SHIFT;
              Busy  <= 1'b1;
              cnt   <= {1'b0, amt};
            end
`ifdef ALU_SEQ_MUL_EN
            else if (OP == OP_MUL) begin
              state <= S_MULT;
              Busy  <= 1'b1;
              cnt   <= CW'(W);
              hi    <= '0;
              lo    <= InputB;
            end
`endif
            else begin
              Out      <= one_res;
              Zero     <= (one_res == '0);
              Carry    <= one_carry;
              Negative <= one_res[W-1];
              Done     <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (cnt == CW'(1)) begin
            Out      <= shifted;
            Zero     <= (shifted == '0);
            Carry    <= shift_bit;
            Negative <= shifted[W-1];
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            work <= shifted;
            cnt  <= cnt - CW'(1);
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MULT: begin
          hi <= next_hi;
          lo <= next_lo;
          if (cnt == CW'(1)) begin
            Out      <= next_lo;
            Zero     <= (next_lo == '0);
            Carry    <= (next_hi != '0);
            Negative <= next_lo[W-1];
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Accepts one operation per Start handshake and produces a registered Out with Zero, Carry and Negative flags.
- Logic and add/sub ops complete in 1 cycle; multi-bit shifts and the optional multiply iterate one step per cycle.
- Sits between the register file read ports and the writeback mux; the controller stalls on Busy.

Parameters:
- W, 8, datapath width in bits (W >= 2).
- SHW, $clog2(W), width of the shift-amount field taken from InputB[SHW-1:0].

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only while Busy=0.
- OP  input  4  opcode, sampled with Start.
- InputA  input  W  operand A, sampled with Start.
- InputB  input  W  operand B, sampled with Start.
- Out  output  W  registered result; holds until the next Done.
- Zero  output  1  registered; 1 when Out==0.
- Carry  output  1  registered; meaning per op (below).
- Negative  output  1  registered; equals Out[W-1].
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle pulse when Out and the flags update.

Behaviour:
- Reset (synchronous, active-high): state IDLE; Out=0, Zero=1, Carry=0, Negative=0, Busy=0, Done=0. Reset mid-operation aborts the operation; no Done is produced.
- States:
  - IDLE: on Start, capture OP, A and B.
  - Single-cycle op: go to IDLE and pulse Done next cycle (latency 1, Busy never rises).
  - Shift with amt>0: go to SHIFT.
  - MUL: go to MULT.
- SHIFT:
  - Shift the working register 1 bit per cycle and decrement amt.
  - When amt reaches 0, write Out and pulse Done, then go to IDLE.
  - Latency = amt+1 cycles after Start; amt = InputB[SHW-1:0].
- MULT: shift-add, one bit of B per cycle, W iterations; Done at cycle W+1.
- Opcodes (Carry meaning in brackets):
  - 0000 ADD: A+B [carry-out].
  - 0001 SUB: A-B [borrow, i.e. A<B unsigned].
  - 0010 XOR [0].
  - 0011 AND [0].
  - 0100 OR [0].
  - 0101 SHL by amt [last bit shifted out; 0 if amt=0].
  - 0110 SHR logical [last bit out].
  - 0111 ASR, sign-filled [last bit out].
  - 1000 MUL [1 if upper W bits of the 2W product are nonzero]; Out = low W bits.
  - All other opcodes: Out=0, Zero=1, Carry=0, 1-cycle Done.
- Arithmetic is modulo 2^W; operands are unsigned except the ASR sign fill.
- Start while Busy=1 is ignored; no queueing.
- Start in the same cycle as Done is legal (Busy=0 then) and is accepted.
- Reset and Start together: Reset wins.
- Out and the flags change only on the Done cycle; they hold otherwise.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL (1000) is implemented as above.
- Undefined: no multiplier or MULT state is built. 1000 is treated as an unused opcode (Out=0, Zero=1, Carry=0, Done after 1 cycle).

Test Plan:
- Reset, then Start ADD with A=0xF0, B=0x20 -> next cycle Done=1, Out=0x10, Carry=1, Zero=0, Negative=0, Busy=0.
- SUB with A=0x05, B=0x05 -> Out=0x00, Zero=1, Carry=0. SUB with A=0x03, B=0x05 -> Out=0xFE, Carry=1, Negative=1.
- SHL with A=0x81, B=0x03 -> Busy high for 3 cycles, Done on cycle 4, Out=0x08, Carry=0. ASR with A=0x80, B=0x07 -> Out=0xFF, Carry=0, Done on cycle 8.
- Start a SHR with B=5; pulse Start with an ADD at cycle 2 -> the ADD is ignored, only one Done, Out = SHR result. Repeat and assert Reset at cycle 3 -> no Done, Out=0, Zero=1, Busy=0.
- With ALU_SEQ_MUL_EN defined: MUL with A=0x10, B=0x11 -> Done on cycle 9, Out=0x10, Carry=1. Without the macro -> Done on cycle 1, Out=0, Zero=1.
- Back-to-back: Start an XOR in the Done cycle of an AND -> two consecutive Done pulses with correct results. Opcode 1111 -> Out=0, Zero=1.
